// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serial UART transmitter with a small input FIFO. Bytes are accepted over a
//   valid/ready handshake and sent as: start bit (0), 8 data bits LSB first,
//   an optional parity bit, then 1 or 2 stop bits (1). Frames that are already
//   queued go out back-to-back with no idle gap. Bit timing is derived
//   internally as Divisor = ClkFrequency / Baud clocks per bit.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   TxD_start  write strobe (valid) for TxD_data
//   TxD_data   byte to queue for transmission
//   TxD_ready  FIFO can accept a byte (registered count < FifoDepth)
//   TxD        serial line, idle high, registered
//   TxD_busy   high while a frame is on the line
//   Tx_done    one-cycle pulse after the last stop bit of each frame
module uart_transmitter #(
    parameter int ClkFrequency = 100000000,
    parameter int Baud         = 115200,
    parameter int Parity       = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int StopBits     = 1,   // 1 or 2
    parameter int FifoDepth    = 4    // power of 2, >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_ready,
    output logic       TxD,
    output logic       TxD_busy,
    output logic       Tx_done
);

    localparam int Divisor = ClkFrequency / Baud;
    localparam int CntW    = $clog2(Divisor);
    localparam int PtrW    = $clog2(FifoDepth);

    // Out-of-range settings fall back to no parity / one stop bit.
    localparam bit ParEn   = (Parity == 1) || (Parity == 2);
    localparam bit ParOdd  = (Parity == 1);
    localparam int NumStop = (StopBits == 2) ? 2 : 1;

    localparam logic [CntW-1:0] BaudLast  = CntW'(Divisor - 1);
    localparam logic [2:0]      StopLast  = 3'(NumStop - 1);
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FifoDepth);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [7:0]      fifo_mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q,  count_d;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [7:0]      fifo_head;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // write even in a cycle where the transmitter pops.
    assign TxD_ready  = (count_q != FullCount);
    assign push       = TxD_start && TxD_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; the count and pointers alone say
    // which entries are valid, and leaving the data unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= TxD_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [7:0]      shift_q,    shift_d;
    logic            par_bit_q,  par_bit_d;
    logic            txd_q,      txd_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            baud_tick;
    logic            load;

    assign baud_tick = (baud_cnt_q == BaudLast);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (state_q != IDLE) begin
            baud_cnt_d = baud_tick ? '0 : baud_cnt_q + CntW'(1);
        end

        unique case (state_q)
            IDLE: begin
                load = !fifo_empty;
            end
            START: begin
                if (baud_tick) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (ParEn) begin
                            txd_d   = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    txd_d     = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == StopLast) begin
                        // Frame complete: chain straight into the next queued
                        // byte, otherwise fall back to idle with the line high.
                        done_d = 1'b1;
                        if (fifo_empty) begin
                            state_d = IDLE;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Pop the FIFO head and begin its start bit.
        if (load) begin
            shift_d    = fifo_head;
            par_bit_d  = (^fifo_head) ^ ParOdd;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            txd_d      = 1'b0;
            state_d    = START;
        end
    end

    assign pop    = load;
    assign busy_d = (state_d != IDLE);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign TxD      = txd_q;
    assign TxD_busy = busy_q;
    assign Tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Four transmitter instances with Divisor = 10 (1000 Hz clock, 100 baud):
//   8N1, even parity, odd parity, and two stop bits. The stimulus process
//   writes bytes to the selected instance and pushes the hand-derived frame
//   description into a queue; the monitor process decodes the selected line,
//   pops the matching entry when a start bit appears and compares every bit
//   cell, the Tx_done pulse and the start timing.
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int Div = 10;

    typedef struct {
        logic [7:0] data;
        int         par;       // -1 = no parity bit, else expected bit value
        int         stops;     // number of stop bits
        int         start_at;  // expected start cycle, -1 = not checked
        bit         b2b;       // must start the cycle the previous frame ended
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] data_in = '0;
    logic [1:0] sel = '0;

    logic txd0, txd1, txd2, txd3;
    logic bsy0, bsy1, bsy2, bsy3;
    logic rdy0, rdy1, rdy2, rdy3;
    logic dn0,  dn1,  dn2,  dn3;
    logic [3:0] txd_v, busy_v, ready_v, done_v;
    logic txd_m, busy_m, ready_m, done_m;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_end = -1;
    bit   mon_active = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_transmitter #(.ClkFrequency(1000), .Baud(100), .Parity(0), .StopBits(1), .FifoDepth(4)) u_8n1 (
        .clk(clk), .rst(rst), .TxD_start(start_v[0]), .TxD_data(data_in),
        .TxD_ready(rdy0), .TxD(txd0), .TxD_busy(bsy0), .Tx_done(dn0));
    uart_transmitter #(.ClkFrequency(1000), .Baud(100), .Parity(2), .StopBits(1), .FifoDepth(4)) u_even (
        .clk(clk), .rst(rst), .TxD_start(start_v[1]), .TxD_data(data_in),
        .TxD_ready(rdy1), .TxD(txd1), .TxD_busy(bsy1), .Tx_done(dn1));
    uart_transmitter #(.ClkFrequency(1000), .Baud(100), .Parity(1), .StopBits(1), .FifoDepth(4)) u_odd (
        .clk(clk), .rst(rst), .TxD_start(start_v[2]), .TxD_data(data_in),
        .TxD_ready(rdy2), .TxD(txd2), .TxD_busy(bsy2), .Tx_done(dn2));
    uart_transmitter #(.ClkFrequency(1000), .Baud(100), .Parity(0), .StopBits(2), .FifoDepth(4)) u_2stop (
        .clk(clk), .rst(rst), .TxD_start(start_v[3]), .TxD_data(data_in),
        .TxD_ready(rdy3), .TxD(txd3), .TxD_busy(bsy3), .Tx_done(dn3));

    assign txd_v   = {txd3, txd2, txd1, txd0};
    assign busy_v  = {bsy3, bsy2, bsy1, bsy0};
    assign ready_v = {rdy3, rdy2, rdy1, rdy0};
    assign done_v  = {dn3,  dn2,  dn1,  dn0};

    always_comb begin
        txd_m   = txd_v[sel];
        busy_m  = busy_v[sel];
        ready_m = ready_v[sel];
        done_m  = done_v[sel];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one write strobe during the next cycle; returns that cycle number.
    task automatic put(input logic [7:0] b, output int at);
        @(negedge clk);
        start_v = 4'b0001 << sel;
        data_in = b;
        at = cyc;
    endtask

    task automatic put_end();
        @(negedge clk);
        start_v = '0;
        data_in = 8'hFF;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int par, input int stops,
                                input int start_at, input bit b2b);
        exp_t e;
        e.data = d; e.par = par; e.stops = stops; e.start_at = start_at; e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_active || busy_m) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_completes"}, 32'(k < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: decode frames on the selected line and score them
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t       e;
        logic [11:0] bitv;
        int         nb;
        int         s;
        bit         have;
        bit         reused;
        bit         aborted;
        bit         done_seen;
        bit         busy_bad;
        logic       seen;
        have = 1'b0;
        forever begin
            reused = have;
            if (!have) @(negedge clk);
            have = 1'b0;
            if (rst) continue;
            if (txd_m == 1'b1) begin
                if (done_m && !reused) begin
                    errors++;
                    $display("FAIL spurious_done: Tx_done=1 while idle (cycle %0d)", cyc);
                end
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: start bit at cycle %0d, nothing queued", cyc);
                for (int k = 0; k < 200 && txd_m == 1'b0; k++) @(negedge clk);
            end else begin
                e = exp_q.pop_front();
                mon_active = 1'b1;
                s = cyc;
                if (e.start_at >= 0) check($sformatf("start_cycle_%02h", e.data), s, e.start_at);
                if (e.b2b) check($sformatf("back_to_back_%02h", e.data), s, last_end);
                bitv = '1;
                bitv[0] = 1'b0;
                for (int i = 0; i < 8; i++) bitv[1 + i] = e.data[i];
                nb = 9;
                if (e.par >= 0) begin
                    bitv[nb] = e.par[0];
                    nb++;
                end
                nb = nb + e.stops;
                aborted = 1'b0;
                done_seen = 1'b0;
                busy_bad = 1'b0;
                for (int b = 0; b < nb && !aborted; b++) begin
                    seen = bitv[b];
                    for (int k = 0; k < Div; k++) begin
                        if (b > 0 || k > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (txd_m !== bitv[b]) seen = txd_m;
                        if ((b > 0 || k > 0) && done_m !== 1'b0) done_seen = 1'b1;
                        if (busy_m !== 1'b1) busy_bad = 1'b1;
                    end
                    if (!aborted) check($sformatf("frame_%02h_bit%0d", e.data, b), 32'(seen), 32'(bitv[b]));
                end
                if (aborted) begin
                    while (rst) @(negedge clk);
                    have = 1'b1;
                end else begin
                    check($sformatf("frame_%02h_no_early_done", e.data), 32'(done_seen), 32'd0);
                    check($sformatf("frame_%02h_busy", e.data), 32'(busy_bad), 32'd0);
                    @(negedge clk);
                    check($sformatf("frame_%02h_done_pulse", e.data), 32'(done_m), 32'd1);
                    check($sformatf("frame_%02h_length", e.data), cyc - s, nb * Div);
                    last_end = cyc;
                    have = 1'b1;
                end
                mon_active = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int  at;
        int  s0;
        bit  low_seen;
        bit  done_seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_txd",   32'(txd_m),   32'd1);
        check("reset_busy",  32'(busy_m),  32'd0);
        check("reset_done",  32'(done_m),  32'd0);
        check("reset_ready", 32'(ready_m), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single 8N1 frame, 0x55
        sel = 2'd0;
        put(8'h55, at);
        expect_frame(8'h55, -1, 1, at + 2, 1'b0);
        put_end();
        wait_idle("t1");
        check("t1_busy_after", 32'(busy_m), 32'd0);

        // 2: two bytes on consecutive cycles, second frame chained
        put(8'hA5, at);
        expect_frame(8'hA5, -1, 1, at + 2, 1'b0);
        put(8'h3C, at);
        expect_frame(8'h3C, -1, 1, -1, 1'b1);
        put_end();
        wait_idle("t2");

        // 3: six writes into a depth-4 FIFO, the sixth is dropped
        put(8'h11, at);
        expect_frame(8'h11, -1, 1, at + 2, 1'b0);
        put(8'h22, at);
        expect_frame(8'h22, -1, 1, -1, 1'b1);
        put(8'h33, at);
        expect_frame(8'h33, -1, 1, -1, 1'b1);
        put(8'h44, at);
        expect_frame(8'h44, -1, 1, -1, 1'b1);
        put(8'h55, at);
        expect_frame(8'h55, -1, 1, -1, 1'b1);
        check("t3_ready_at_E", 32'(ready_m), 32'd1);
        put(8'h66, at);
        check("t3_ready_full", 32'(ready_m), 32'd0);
        put_end();
        wait_idle("t3");
        check("t3_ready_after", 32'(ready_m), 32'd1);

        // 4: parity, 0x07 has three ones -> even bit 1, odd bit 0
        sel = 2'd1;
        put(8'h07, at);
        expect_frame(8'h07, 1, 1, at + 2, 1'b0);
        put_end();
        wait_idle("t4_even");
        sel = 2'd2;
        put(8'h07, at);
        expect_frame(8'h07, 0, 1, at + 2, 1'b0);
        put_end();
        wait_idle("t4_odd");

        // 5: two stop bits with 0x00
        sel = 2'd3;
        put(8'h00, at);
        expect_frame(8'h00, -1, 2, at + 2, 1'b0);
        put_end();
        wait_idle("t5");

        // 6: reset 45 cycles into a frame with two more bytes queued
        sel = 2'd0;
        put(8'h12, at);
        expect_frame(8'h12, -1, 1, at + 2, 1'b0);
        s0 = at + 2;
        put(8'h34, at);
        put(8'h56, at);
        put_end();
        while (cyc < s0 + 45) @(negedge clk);
        check("t6_busy_before", 32'(busy_m), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_txd_after_rst",   32'(txd_m),   32'd1);
        check("t6_busy_after_rst",  32'(busy_m),  32'd0);
        check("t6_ready_after_rst", 32'(ready_m), 32'd1);
        check("t6_done_after_rst",  32'(done_m),  32'd0);
        rst = 1'b0;
        low_seen = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (txd_m == 1'b0) low_seen = 1'b1;
            if (done_m == 1'b1) done_seen = 1'b1;
        end
        check("t6_line_quiet", 32'(low_seen),  32'd0);
        check("t6_no_done",    32'(done_seen), 32'd0);
        put(8'h81, at);
        expect_frame(8'h81, -1, 1, at + 2, 1'b0);
        put_end();
        wait_idle("t6_after");

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
